// File: rtl/data_packer.sv
// data_packer: packs RATIO consecutive WIDTH-bit beats into one registered
// WIDTH*RATIO-bit word, with beat 0 in the lowest lane.
//
// Ports:
//   clk, rst_n         clock, asynchronous active-low reset
//   m_valid/m_ready    upstream beat handshake, m_data beat payload
//   s_valid/s_ready    downstream word handshake, s_data packed word
// Optional (macro DATA_PACKER_LAST_EN):
//   m_last             closes the current word early
//   s_last, s_keep     early-close flag and filled-lane mask for s_data
module data_packer #(
    parameter int WIDTH = 8,
    parameter int RATIO = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   m_valid,
    output logic                   m_ready,
    input  logic [WIDTH-1:0]       m_data,
    output logic                   s_valid,
    input  logic                   s_ready,
    output logic [WIDTH*RATIO-1:0] s_data
`ifdef DATA_PACKER_LAST_EN
    ,
    input  logic                   m_last,
    output logic                   s_last,
    output logic [RATIO-1:0]       s_keep
`endif
);

    localparam int CW = (RATIO > 1) ? $clog2(RATIO) : 1;
    localparam int DW = WIDTH * RATIO;
    localparam logic [CW-1:0] LAST_CNT = CW'(RATIO - 1);

    logic [CW-1:0] cnt;
    logic [DW-1:0] buffer;
    logic [DW-1:0] word_next;
    logic          last_slot;
    logic          early;
    logic          acc;
    logic          fin;
    logic          out_fire;

    assign last_slot = (cnt == LAST_CNT);

`ifdef DATA_PACKER_LAST_EN
    logic [RATIO-1:0] keep_next;

    // A beat flagged last may complete the word at any lane, so it is
    // held off exactly like a final beat while the output is stalled.
    assign early   = m_valid && m_last;
    assign m_ready = (!last_slot && !early) || !s_valid || s_ready;
    assign fin     = last_slot || m_last;

    always_comb begin
        keep_next = '0;
        for (int k = 0; k < RATIO; k++) begin
            if (CW'(k) <= cnt) keep_next[k] = 1'b1;
        end
    end
`else
    assign early   = 1'b0;
    assign m_ready = !last_slot || !s_valid || s_ready;
    assign fin     = last_slot;
`endif

    assign acc      = m_valid && m_ready;
    assign out_fire = s_valid && s_ready;

    // Lanes at or above cnt are always zero in the buffer, so inserting
    // the incoming beat yields a word whose unfilled lanes read as zero.
    always_comb begin
        word_next = buffer;
        for (int k = 0; k < RATIO; k++) begin
            if (CW'(k) == cnt) word_next[k*WIDTH +: WIDTH] = m_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt    <= '0;
            buffer <= '0;
        end else if (acc) begin
            if (fin) begin
                cnt    <= '0;
                buffer <= '0;
            end else begin
                cnt    <= cnt + CW'(1);
                buffer <= word_next;
            end
        end
    end

    // A completing beat can only be accepted when the output slot is
    // free or draining, so loading here never overwrites a held word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_valid <= 1'b0;
            s_data  <= '0;
        end else if (acc && fin) begin
            s_valid <= 1'b1;
            s_data  <= word_next;
        end else if (out_fire) begin
            s_valid <= 1'b0;
        end
    end

`ifdef DATA_PACKER_LAST_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_last <= 1'b0;
            s_keep <= '0;
        end else if (acc && fin) begin
            s_last <= m_last;
            s_keep <= keep_next;
        end
    end
`endif

    logic unused;
    assign unused = early;

endmodule

// File: tb/tb_data_packer.sv
// tb_data_packer: directed and randomized checks of data_packer against
// a queue-based reference model of beat packing.
module tb_data_packer;

    localparam int WIDTH = 8;
    localparam int RATIO = 4;
    localparam int DW    = WIDTH * RATIO;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             m_valid;
    logic             m_ready;
    logic [WIDTH-1:0] m_data;
    logic             s_valid;
    logic             s_ready;
    logic [DW-1:0]    s_data;
`ifdef DATA_PACKER_LAST_EN
    logic             m_last;
    logic             s_last;
    logic [RATIO-1:0] s_keep;
`endif

    always #5 clk = ~clk;

    data_packer #(.WIDTH(WIDTH), .RATIO(RATIO)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .m_valid (m_valid),
        .m_ready (m_ready),
        .m_data  (m_data),
        .s_valid (s_valid),
        .s_ready (s_ready),
        .s_data  (s_data)
`ifdef DATA_PACKER_LAST_EN
        ,
        .m_last  (m_last),
        .s_last  (s_last),
        .s_keep  (s_keep)
`endif
    );

    int checks = 0;
    int errors = 0;

    // Reference model: beats collected so far and the word on offer.
    logic [WIDTH-1:0] mq[$];
    bit               pend;
    logic [DW-1:0]    exp_word;
`ifdef DATA_PACKER_LAST_EN
    logic [RATIO-1:0] exp_keep;
    bit               exp_last;
`endif

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    function automatic bit model_ready();
        bit room;
        room = (mq.size() != RATIO - 1);
`ifdef DATA_PACKER_LAST_EN
        room = room && !(m_valid && m_last);
`endif
        return room || !pend || s_ready;
    endfunction

    task automatic step();
        bit acc;
        bit fire;
        bit close;
        @(negedge clk);
        check("m_ready", m_ready, model_ready());
        check("s_valid", s_valid, pend);
        if (pend) begin
            check("s_data", s_data, exp_word);
`ifdef DATA_PACKER_LAST_EN
            check("s_keep", s_keep, exp_keep);
            check("s_last", s_last, exp_last);
`endif
        end
        acc  = m_valid && model_ready();
        fire = pend && s_ready;
        if (fire) pend = 0;
        if (acc) begin
            mq.push_back(m_data);
            close = (mq.size() == RATIO);
`ifdef DATA_PACKER_LAST_EN
            exp_last = m_last;
            close = close || m_last;
            exp_keep = '0;
            for (int k = 0; k < mq.size(); k++) exp_keep[k] = 1'b1;
`endif
            if (close) begin
                exp_word = '0;
                for (int k = 0; k < mq.size(); k++)
                    exp_word = exp_word | (DW'(mq[k]) << (k * WIDTH));
                pend = 1;
                mq.delete();
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input logic v, input logic [WIDTH-1:0] d,
                        input logic r);
        m_valid = v;
        m_data  = d;
        s_ready = r;
        step();
    endtask

    initial begin
        rst_n   = 1'b0;
        m_valid = 1'b0;
        m_data  = '0;
        s_ready = 1'b1;
`ifdef DATA_PACKER_LAST_EN
        m_last  = 1'b0;
`endif
        pend = 0;
        #1;
        check("rst_s_valid", s_valid, 0);
        check("rst_s_data", s_data, 0);
        check("rst_m_ready", m_ready, 1);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Single word, open output.
        beat(1, 8'h11, 1);
        beat(1, 8'h22, 1);
        beat(1, 8'h33, 1);
        beat(1, 8'h44, 1);
        check("t1_valid", s_valid, 1);
        check("t1_word", s_data, 32'h44332211);
        beat(0, 8'h00, 1);
        check("t1_pulse", s_valid, 0);

        // Continuous flow, 16 beats.
        for (int i = 0; i < 16; i++) begin
            beat(1, WIDTH'(i), 1);
            if (i == 7) check("t2_word1", s_data, 32'h07060504);
        end
        check("t2_word3", s_data, 32'h0F0E0D0C);
        beat(0, 8'h00, 1);

        // Downstream stall with final beat held off.
        beat(1, 8'h11, 1);
        beat(1, 8'h22, 1);
        beat(1, 8'h33, 1);
        beat(1, 8'h44, 1);
        beat(1, 8'h55, 0);
        beat(1, 8'h66, 0);
        beat(1, 8'h77, 0);
        m_valid = 1'b1;
        m_data  = 8'h88;
        s_ready = 1'b0;
        #1;
        check("t3_stall", m_ready, 0);
        step();
        step();
        check("t3_hold", s_data, 32'h44332211);
        beat(1, 8'h88, 1);
        check("t3_nobubble_v", s_valid, 1);
        check("t3_nobubble_d", s_data, 32'h88776655);
        beat(0, 8'h00, 1);

        // Reset in the middle of a word.
        beat(1, 8'hAA, 1);
        beat(1, 8'hBB, 1);
        rst_n = 1'b0;
        #1;
        check("t4_rst_valid", s_valid, 0);
        check("t4_rst_data", s_data, 0);
        check("t4_rst_ready", m_ready, 1);
        mq.delete();
        pend = 0;
        @(posedge clk);
        #1;
        check("t4_rst_hold", s_data, 0);
        rst_n = 1'b1;
        beat(1, 8'h01, 1);
        beat(1, 8'h02, 1);
        beat(1, 8'h03, 1);
        beat(1, 8'h04, 1);
        check("t4_word", s_data, 32'h04030201);
        beat(0, 8'h00, 1);

`ifdef DATA_PACKER_LAST_EN
        // Early close on m_last.
        beat(1, 8'h55, 1);
        m_last = 1'b1;
        beat(1, 8'h66, 1);
        m_last = 1'b0;
        check("t5_word", s_data, 32'h00006655);
        check("t5_keep", s_keep, 4'b0011);
        check("t5_last", s_last, 1);
        for (int i = 0; i < 4; i++) beat(1, WIDTH'(8'hC0 + i), 1);
        check("t5_lane0", s_data, 32'hC3C2C1C0);
        check("t5_full_keep", s_keep, 4'b1111);
        beat(0, 8'h00, 1);
`endif

        // Randomized flow and back-pressure.
        for (int i = 0; i < 1500; i++) begin
`ifdef DATA_PACKER_LAST_EN
            m_last = ($urandom_range(0, 7) == 0);
`endif
            beat($urandom_range(0, 3) != 0, WIDTH'($urandom),
                 $urandom_range(0, 4) > 1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
